// File: rtl/css_mcu0_el2_pkg.sv
// Shared EL2 package for the MCU0 PMP slice.
// Provides the pmpcfg byte layout, the PMP address-matching modes, the
// access-type encoding used by sequential PMP requesters, and the state
// encoding of the sequential checker FSM.
package css_mcu0_el2_pkg;

  // PMP address-matching mode (pmpcfg.A field).
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } el2_pmp_mode_pkt_t;

  // One pmpcfg byte, MSB first.
  typedef struct packed {
    logic              lock;
    logic [1:0]        reserved;
    el2_pmp_mode_pkt_t mode;
    logic              execute;
    logic              write;
    logic              read;
  } el2_pmp_cfg_pkt_t;

  // Access type carried with each sequential PMP request; encoding 3 is
  // treated as a read by the checker.
  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    EXEC  = 2'd2
  } el2_pmp_acc_type_e;

  // Sequential checker FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } el2_pmp_seq_state_e;

endpackage

// File: rtl/css_mcu0_el2_pmp_entry_match.sv
// Single PMP entry address-match and permission evaluator (combinational).
// Shared by the sequential checker: the caller muxes in one entry's config
// and addresses per cycle.
// Ports:
//   addr         byte address of the access
//   acc_type     access type (READ/WRITE/EXEC, 3 behaves as READ)
//   mmode        1 = machine mode, 0 = user mode
//   cfg          pmpcfg of the entry under test
//   pmpaddr      pmpaddr of the entry under test (word units)
//   prev_pmpaddr pmpaddr of the previous entry (TOR lower bound, 0 for entry 0)
//   match        entry matches the address
//   perm         access permitted if this entry is the deciding one
module css_mcu0_el2_pmp_entry_match
  import css_mcu0_el2_pkg::*;
(
  input  logic [31:0]      addr,
  input  logic [1:0]       acc_type,
  input  logic             mmode,
  input  el2_pmp_cfg_pkt_t cfg,
  input  logic [31:0]      pmpaddr,
  input  logic [31:0]      prev_pmpaddr,
  output logic             match,
  output logic             perm
);

  logic [31:0] word_addr;
  logic [31:0] napot_mask;
  logic        unused_bits;

  assign word_addr = {2'b00, addr[31:2]};

  // pmpaddr ^ (pmpaddr + 1) sets bits 0..t where t is the trailing-ones
  // count, so its inverse keeps only the bits that must agree (31..t+1).
  assign napot_mask = ~(pmpaddr ^ (pmpaddr + 32'd1));

  assign unused_bits = ^{addr[1:0], cfg.reserved};

  always_comb begin
    match = 1'b0;
    case (cfg.mode)
      OFF:   match = 1'b0;
      NA4:   match = (word_addr == pmpaddr);
      TOR:   match = (word_addr >= prev_pmpaddr) && (word_addr < pmpaddr);
      NAPOT: match = (((word_addr ^ pmpaddr) & napot_mask) == 32'd0);
      default: match = 1'b0;
    endcase
  end

  // Machine mode bypasses unlocked entries; locked entries and user mode
  // are bound by the R/W/X bits.
  always_comb begin
    perm = 1'b1;
    if (cfg.lock || !mmode) begin
      case (acc_type)
        WRITE:   perm = cfg.write;
        EXEC:    perm = cfg.execute;
        default: perm = cfg.read;
      endcase
    end
  end

endmodule

// File: rtl/css_mcu0_el2_pmp_seq_chk.sv
// Sequential PMP checker shared among NUM_REQ requesters.
// Round-robin accepts one request, walks PMP entries 0..PMP_ENTRIES-1 one
// per cycle through a single entry evaluator, and returns the verdict of
// the lowest-numbered matching entry.
// Ports:
//   clk, rst_l        clock, asynchronous active-low reset
//   req_valid/addr/type/mmode  per-requester request
//   req_ready         one-hot accept strobe (combinational)
//   pmp_pmpcfg/pmpaddr live PMP CSR state
//   pmp_cfg_wr        PMP CSR write committing this cycle (restarts a walk)
//   resp_valid/id/err/match/entry  one-cycle verdict
//   busy              checker not idle
module css_mcu0_el2_pmp_seq_chk
  import css_mcu0_el2_pkg::*;
#(
  parameter int PMP_ENTRIES = 16,
  parameter int NUM_REQ     = 2,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_l,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][31:0]               req_addr,
  input  logic [NUM_REQ-1:0][1:0]                req_type,
  input  logic [NUM_REQ-1:0]                     req_mmode,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  el2_pmp_cfg_pkt_t [PMP_ENTRIES-1:0]     pmp_pmpcfg,
  input  logic [PMP_ENTRIES-1:0][31:0]           pmp_pmpaddr,
  input  logic                                   pmp_cfg_wr,
  output logic                                   resp_valid,
  output logic [ID_W-1:0]                        resp_id,
  output logic                                   resp_err,
  output logic                                   resp_match,
  output logic [5:0]                             resp_entry,
  output logic                                   busy
);

  el2_pmp_seq_state_e state, state_nxt;

  logic [5:0]       idx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic             any_req;

  logic [31:0]      lat_addr;
  logic [1:0]       lat_type;
  logic             lat_mmode;
  logic [ID_W-1:0]  lat_id;
  logic             lat_match;
  logic [5:0]       lat_entry;
  logic             lat_perm;

  el2_pmp_cfg_pkt_t cur_cfg;
  logic [31:0]      cur_pmpaddr;
  logic [31:0]      prev_pmpaddr;
  logic             ent_match;
  logic             ent_perm;
  logic             last_entry;

  // Round-robin: search starting one past the last winner.
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_req && (j == ((int'(rr_ptr) + i) % NUM_REQ)) && req_valid[j]) begin
          any_req = 1'b1;
          winner  = ID_W'(j);
        end
      end
    end
  end

  // Entry mux; entry 0 uses a TOR lower bound of zero.
  always_comb begin
    cur_cfg      = '0;
    cur_pmpaddr  = '0;
    prev_pmpaddr = '0;
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      if (idx == 6'(e)) begin
        cur_cfg     = pmp_pmpcfg[e];
        cur_pmpaddr = pmp_pmpaddr[e];
      end
    end
    for (int e = 1; e < PMP_ENTRIES; e++) begin
      if (idx == 6'(e)) begin
        prev_pmpaddr = pmp_pmpaddr[e-1];
      end
    end
  end

  assign last_entry = (idx == 6'(PMP_ENTRIES - 1));

  css_mcu0_el2_pmp_entry_match u_entry_match (
    .addr         (lat_addr),
    .acc_type     (lat_type),
    .mmode        (lat_mmode),
    .cfg          (cur_cfg),
    .pmpaddr      (cur_pmpaddr),
    .prev_pmpaddr (prev_pmpaddr),
    .match        (ent_match),
    .perm         (ent_perm)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A CSR write during WALK holds the FSM in WALK so the restart wins over
  // a simultaneous match or end-of-walk.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = WALK;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
          req_ready[j] = any_req && (winner == ID_W'(j));
        end
      end
      WALK: begin
        if (!pmp_cfg_wr && (ent_match || last_entry)) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      idx       <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      lat_addr  <= '0;
      lat_type  <= '0;
      lat_mmode <= 1'b0;
      lat_id    <= '0;
      lat_match <= 1'b0;
      lat_entry <= '0;
      lat_perm  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            for (int j = 0; j < NUM_REQ; j++) begin
              if (winner == ID_W'(j)) begin
                lat_addr  <= req_addr[j];
                lat_type  <= req_type[j];
                lat_mmode <= req_mmode[j];
              end
            end
            rr_ptr <= winner;
            lat_id <= winner;
            idx    <= '0;
          end
        end
        WALK: begin
          if (pmp_cfg_wr) begin
            idx <= '0;
          end else if (ent_match) begin
            lat_match <= 1'b1;
            lat_entry <= idx;
            lat_perm  <= ent_perm;
          end else if (last_entry) begin
            // No entry matched: M-mode is allowed, U-mode is denied.
            lat_match <= 1'b0;
            lat_entry <= '0;
            lat_perm  <= lat_mmode;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && !lat_perm;
  assign resp_id    = lat_id;
  assign resp_match = lat_match;
  assign resp_entry = lat_entry;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_css_mcu0_el2_pmp_seq_chk.sv
// Scoreboard testbench for css_mcu0_el2_pmp_seq_chk (16 entries, 2 requesters).
// Stimulus records per-requester expected verdicts; the monitor predicts the
// round-robin winner at each grant, queues the expected response with its
// due cycle, and checks every resp_valid against the queue head.
module tb_css_mcu0_el2_pmp_seq_chk;
  import css_mcu0_el2_pkg::*;

  localparam int PMP_ENTRIES = 16;
  localparam int NUM_REQ     = 2;

  logic                               clk = 1'b0;
  logic                               rst_l;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][31:0]           req_addr;
  logic [NUM_REQ-1:0][1:0]            req_type;
  logic [NUM_REQ-1:0]                 req_mmode;
  logic [NUM_REQ-1:0]                 req_ready;
  el2_pmp_cfg_pkt_t [PMP_ENTRIES-1:0] pmp_pmpcfg;
  logic [PMP_ENTRIES-1:0][31:0]       pmp_pmpaddr;
  logic                               pmp_cfg_wr;
  logic                               resp_valid;
  logic [0:0]                         resp_id;
  logic                               resp_err;
  logic                               resp_match;
  logic [5:0]                         resp_entry;
  logic                               busy;

  typedef struct {
    int id;
    int err;
    int match;
    int entry;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   exp_err   [NUM_REQ];
  int   exp_match [NUM_REQ];
  int   exp_entry [NUM_REQ];
  int   exp_lat   [NUM_REQ];

  int tests_run       = 0;
  int fails           = 0;
  int cyc             = 0;
  int rr_model        = NUM_REQ - 1;
  int grant_count     = 0;
  int last_accept_cyc = 0;

  css_mcu0_el2_pmp_seq_chk #(
    .PMP_ENTRIES (PMP_ENTRIES),
    .NUM_REQ     (NUM_REQ)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .req_mmode   (req_mmode),
    .req_ready   (req_ready),
    .pmp_pmpcfg  (pmp_pmpcfg),
    .pmp_pmpaddr (pmp_pmpaddr),
    .pmp_cfg_wr  (pmp_cfg_wr),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_err    (resp_err),
    .resp_match  (resp_match),
    .resp_entry  (resp_entry),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: grant prediction plus response scoreboard, sampled on negedge.
  always @(negedge clk) begin : monitor
    int                 win;
    logic [NUM_REQ-1:0] want;
    exp_t               e;
    if (!rst_l) begin
      exp_q.delete();
      rr_model = NUM_REQ - 1;
    end else begin
      if (req_ready != '0) begin
        win = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
          if (win < 0 && req_valid[(rr_model + i) % NUM_REQ]) win = (rr_model + i) % NUM_REQ;
        end
        want = '0;
        if (win >= 0) want[win] = 1'b1;
        checkOutput("grant", int'(req_ready), int'(want));
        if (win >= 0) begin
          e.id    = win;
          e.err   = exp_err[win];
          e.match = exp_match[win];
          e.entry = exp_entry[win];
          e.due   = cyc + exp_lat[win];
          exp_q.push_back(e);
          rr_model        = win;
          grant_count     = grant_count + 1;
          last_accept_cyc = cyc;
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_cycle", cyc, e.due);
          checkOutput("resp_id", int'(resp_id), e.id);
          checkOutput("resp_err", int'(resp_err), e.err);
          checkOutput("resp_match", int'(resp_match), e.match);
          checkOutput("resp_entry", int'(resp_entry), e.entry);
        end
      end
    end
  end

  task automatic clearCfg();
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      pmp_pmpcfg[e]  = '0;
      pmp_pmpaddr[e] = '0;
    end
  endtask

  task automatic setCfg(input int e, input logic l, input logic [1:0] mode,
                        input logic x, input logic w, input logic r, input logic [31:0] a);
    pmp_pmpcfg[e]  = el2_pmp_cfg_pkt_t'({l, 2'b00, mode, x, w, r});
    pmp_pmpaddr[e] = a;
  endtask

  task automatic setExpect(input int id, input int err, input int match, input int entry, input int lat);
    exp_err[id]   = err;
    exp_match[id] = match;
    exp_entry[id] = entry;
    exp_lat[id]   = lat;
  endtask

  task automatic setReq(input int id, input logic [31:0] addr, input logic [1:0] t, input logic m);
    req_addr[id]  = addr;
    req_type[id]  = t;
    req_mmode[id] = m;
  endtask

  // Returns #1 after the posedge that follows the target grant.
  task automatic waitGrants(input int target);
    int k = 0;
    while (grant_count < target && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (grant_count < target) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL grant_timeout: got %0d grants, expected %0d", grant_count, target);
    end
  endtask

  task automatic waitIdle();
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while ((exp_q.size() != 0 || busy) && k < 300);
    if (exp_q.size() != 0 || busy) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL resp_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  // Single-requester transaction: raise valid, hold until granted, drop.
  task automatic applyStimulus(input int id, input logic [31:0] addr, input logic [1:0] t,
                               input logic m, input int err, input int match,
                               input int entry, input int lat);
    setExpect(id, err, match, entry, lat);
    setReq(id, addr, t, m);
    req_valid[id] = 1'b1;
    waitGrants(grant_count + 1);
    req_valid[id] = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    rst_l      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_type   = '0;
    req_mmode  = '0;
    pmp_cfg_wr = 1'b0;
    clearCfg();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", int'(req_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_resp_valid", int'(resp_valid), 0);
    checkOutput("rst_resp_err", int'(resp_err), 0);
    checkOutput("rst_resp_match", int'(resp_match), 0);
    checkOutput("rst_resp_id", int'(resp_id), 0);
    checkOutput("rst_resp_entry", int'(resp_entry), 0);
    @(posedge clk);
    #1 rst_l = 1'b1;
    @(posedge clk);
    #1;

    // Locked NA4 entry 3 denies a U-mode write: resp at A+5
    clearCfg();
    setCfg(3, 1'b1, NA4, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
    applyStimulus(0, 32'h0000_1000, WRITE, 1'b0, 1, 1, 3, 5);
    checkOutput("busy_walk", int'(busy), 1);
    waitIdle();

    // All entries OFF: M-mode allowed, U-mode denied, resp at A+17
    clearCfg();
    applyStimulus(0, 32'h0000_1234, READ, 1'b1, 0, 0, 0, 17);
    waitIdle();
    applyStimulus(0, 32'h0000_1234, READ, 1'b0, 1, 0, 0, 17);
    waitIdle();

    // TOR entry 0 below 0x1000 bytes, NAPOT entry 1 over 0x0000-0x3FFF
    clearCfg();
    setCfg(0, 1'b0, TOR,   1'b1, 1'b0, 1'b0, 32'h0000_0400);
    setCfg(1, 1'b0, NAPOT, 1'b0, 1'b0, 1'b1, 32'h0000_07FF);
    applyStimulus(0, 32'h0000_1FFC, EXEC, 1'b0, 1, 1, 1, 3);
    waitIdle();
    applyStimulus(0, 32'h0000_0FFC, EXEC, 1'b0, 0, 1, 0, 2);
    waitIdle();
    applyStimulus(0, 32'h0000_1000, READ, 1'b0, 0, 1, 1, 3);
    waitIdle();
    applyStimulus(1, 32'h0000_1FFC, EXEC, 1'b1, 0, 1, 1, 3);
    waitIdle();

    // Both requesters held valid: grants alternate 0,1,0,1
    setExpect(0, 0, 1, 0, 2);
    setExpect(1, 1, 1, 1, 3);
    setReq(0, 32'h0000_0FFC, EXEC, 1'b0);
    setReq(1, 32'h0000_1FFC, EXEC, 1'b0);
    req_valid = 2'b11;
    waitGrants(grant_count + 4);
    req_valid = 2'b00;
    waitIdle();

    // CSR write at A+3 restarts the walk; entry 5 now locked with R=0
    clearCfg();
    setCfg(5, 1'b0, NA4, 1'b0, 1'b0, 1'b1, 32'h0000_0800);
    applyStimulus(0, 32'h0000_2000, READ, 1'b0, 1, 1, 5, 10);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("cfg_wr_cycle", cyc, last_accept_cyc + 3);
    pmp_cfg_wr = 1'b1;
    setCfg(5, 1'b1, NA4, 1'b0, 1'b0, 1'b0, 32'h0000_0800);
    @(posedge clk);
    #1 pmp_cfg_wr = 1'b0;
    waitIdle();

    // Reset at A+2 aborts the walk; afterwards req0 wins first again
    clearCfg();
    applyStimulus(0, 32'h0000_3000, READ, 1'b1, 0, 0, 0, 17);
    @(posedge clk);
    #1 rst_l = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_resp_valid", int'(resp_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    setExpect(0, 0, 0, 0, 17);
    setExpect(1, 0, 0, 0, 17);
    setReq(0, 32'h0000_3000, READ, 1'b1);
    setReq(1, 32'h0000_3004, READ, 1'b1);
    req_valid = 2'b11;
    waitGrants(grant_count + 2);
    req_valid = 2'b00;
    waitIdle();

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
